// File: rtl/out_wrmem_fsm_if.sv
// Token-input and memory-write signal bundle for out_wrmem_fsm.
// The master side is the write controller; the slave side is the producer port plus memory.
interface out_wrmem_fsm_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();
    logic              OUT_send;
    logic [DATA_W-1:0] OUT_data;
    logic              IN_rdy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        input  OUT_send,
        input  OUT_data,
        output IN_rdy,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_data
    );

    modport slave (
        output OUT_send,
        output OUT_data,
        input  IN_rdy,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );
endinterface

// File: rtl/out_wrmem_fsm.sv
// Burst write controller: drains an output port into local memory, arbitrating via the port selector.
// Optional macro OUT_WRMEM_STALL_CNT_EN adds a saturating stall_cnt output.
module out_wrmem_fsm #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              selected,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  size,
    input  logic [CNT_W-1:0]  burst_len,
    out_wrmem_fsm_if.master   bus,
    output logic              portEn,
    output logic              free,
    output logic              done
`ifdef OUT_WRMEM_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RECV = 3'd2,
        S_FREE = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]  blen_q, blen_d;
    logic              start_prev_q, start_prev_d;
    logic              in_rdy_q, in_rdy_d;
    logic              free_q, free_d;
    logic              done_q, done_d;
    logic              capture;
    logic              xfer;
    logic              last_xfer;

`ifdef OUT_WRMEM_STALL_CNT_EN
    logic [15:0]       stall_cnt_q, stall_cnt_d;
`endif

    assign xfer      = bus.OUT_send && in_rdy_q;
    assign last_xfer = (burst_cnt_q == blen_q - CNT_W'(1)) || (remaining_q == CNT_W'(1));
    assign capture   = (state_q == S_IDLE) && start && !start_prev_q;

    always_comb begin
        state_d      = state_q;
        addr_ptr_d   = addr_ptr_q;
        remaining_d  = remaining_q;
        burst_cnt_d  = burst_cnt_q;
        blen_d       = blen_q;
        start_prev_d = start;

        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    addr_ptr_d  = base_addr;
                    remaining_d = size;
                    blen_d      = (burst_len == '0) ? CNT_W'(1) : burst_len;
                    burst_cnt_d = '0;
                    state_d     = S_ARM;
                end
            end
            S_ARM: begin
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else if (selected) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (xfer) begin
                    addr_ptr_d  = addr_ptr_q + ADDR_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (last_xfer) begin
                        state_d = S_FREE;
                    end
                end
            end
            S_FREE: begin
                burst_cnt_d = '0;
                state_d     = (remaining_q != '0) ? S_ARM : S_DONE;
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up with state_q.
        in_rdy_d = (state_d == S_RECV);
        free_d   = (state_d == S_FREE);
        done_d   = (state_d == S_DONE);
    end

`ifdef OUT_WRMEM_STALL_CNT_EN
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (capture) begin
            stall_cnt_d = '0;
        end else if ((state_q == S_RECV) && !bus.OUT_send && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_ptr_q   <= '0;
            remaining_q  <= '0;
            burst_cnt_q  <= '0;
            blen_q       <= '0;
            start_prev_q <= 1'b0;
            in_rdy_q     <= 1'b0;
            free_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_ptr_q   <= addr_ptr_d;
            remaining_q  <= remaining_d;
            burst_cnt_q  <= burst_cnt_d;
            blen_q       <= blen_d;
            start_prev_q <= start_prev_d;
            in_rdy_q     <= in_rdy_d;
            free_q       <= free_d;
            done_q       <= done_d;
        end
    end

    // Selector request is Mealy so it drops in the same cycle the grant arrives.
    assign portEn       = (state_q == S_ARM) && (remaining_q != '0) && !selected;
    assign free         = free_q;
    assign done         = done_q;
    assign bus.IN_rdy   = in_rdy_q;
    assign bus.mem_en   = xfer;
    assign bus.mem_we   = xfer;
    assign bus.mem_addr = addr_ptr_q;
    assign bus.mem_data = bus.OUT_data;

endmodule

// File: tb/tb_out_wrmem_fsm.sv
// Directed per-cycle vector bench for out_wrmem_fsm; each row drives inputs and
// checks the outputs seen in that same cycle before the next rising edge.
module tb_out_wrmem_fsm;

    logic        clk;
    logic        rst;
    logic        start;
    logic        selected;
    logic [11:0] base_addr;
    logic [15:0] size;
    logic [15:0] burst_len;
    logic        portEn;
    logic        free;
    logic        done;
`ifdef OUT_WRMEM_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks;
    int errors;

    out_wrmem_fsm_if #(.ADDR_W(12), .DATA_W(32)) bus_if ();

    out_wrmem_fsm #(.ADDR_W(12), .DATA_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .selected  (selected),
        .base_addr (base_addr),
        .size      (size),
        .burst_len (burst_len),
        .bus       (bus_if),
        .portEn    (portEn),
        .free      (free),
        .done      (done)
`ifdef OUT_WRMEM_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        sel;
        logic        send;
        logic [31:0] data;
        logic        rdy;
        logic        en;
        logic [11:0] addr;
        logic        pe;
        logic        fr;
        logic        dn;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic sl, logic snd, logic [31:0] d,
                                logic rdy, logic en, logic [11:0] a,
                                logic pe, logic fr, logic dn);
        vec_t v;
        v.start = s;   v.sel = sl;  v.send = snd; v.data = d;
        v.rdy   = rdy; v.en  = en;  v.addr = a;
        v.pe    = pe;  v.fr  = fr;  v.dn   = dn;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx, input vec_t v);
        logic [49:0] act;
        logic [49:0] exp;
        act = {bus_if.IN_rdy, bus_if.mem_en, bus_if.mem_we, portEn, free, done,
               bus_if.mem_addr, bus_if.mem_data};
        exp = {v.rdy, v.en, v.en, v.pe, v.fr, v.dn, v.addr, v.data};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s[%0d]: got rdy/en/we/pe/free/done=%b addr=%h data=%h, expected %b addr=%h data=%h",
                     name, idx, act[49:44], act[43:32], act[31:0],
                     exp[49:44], exp[43:32], exp[31:0]);
        end
    endtask

    task automatic applyStimulus(input string name, input int idx, input vec_t v);
        @(negedge clk);
        start              = v.start;
        selected           = v.sel;
        bus_if.OUT_send    = v.send;
        bus_if.OUT_data    = v.data;
        #1;
        checkOutput(name, idx, v);
    endtask

    task automatic runTable(input string name);
        foreach (vecs[i]) applyStimulus(name, i, vecs[i]);
        vecs.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        selected = 1'b0;
        base_addr = '0;
        size = '0;
        burst_len = '0;
        bus_if.OUT_send = 1'b0;
        bus_if.OUT_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single burst covering the whole transfer; first row is the reset state.
        base_addr = 12'h010; size = 16'd4; burst_len = 16'd4;
        vecs.push_back(mk(0,1,1,32'hA0, 0,0,12'h000,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA0, 0,0,12'h000,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA0, 0,0,12'h010,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA0, 1,1,12'h010,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA1, 1,1,12'h011,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA2, 1,1,12'h012,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA3, 1,1,12'h013,0,0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h014,0,1,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h014,0,0,1));
        vecs.push_back(mk(0,1,0,32'h00, 0,0,12'h014,0,0,1));
        vecs.push_back(mk(0,1,0,32'h00, 0,0,12'h014,0,0,0));
        runTable("burst4");

        // Bursts of 2,2,1 with ARM re-entered between them.
        base_addr = 12'h010; size = 16'd5; burst_len = 16'd2;
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h014,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA0, 0,0,12'h010,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA0, 1,1,12'h010,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA1, 1,1,12'h011,0,0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h012,0,1,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h012,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA2, 1,1,12'h012,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA3, 1,1,12'h013,0,0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h014,0,1,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h014,0,0,0));
        vecs.push_back(mk(1,1,1,32'hA4, 1,1,12'h014,0,0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h015,0,1,0));
        vecs.push_back(mk(0,1,0,32'h00, 0,0,12'h015,0,0,1));
        vecs.push_back(mk(0,1,0,32'h00, 0,0,12'h015,0,0,0));
        runTable("burst2");

        // Selector withheld for 3 ARM cycles, then OUT_send stalls 1,0,0,1.
        base_addr = 12'h100; size = 16'd2; burst_len = 16'd4;
        vecs.push_back(mk(1,0,0,32'h00, 0,0,12'h015,0,0,0));
        vecs.push_back(mk(1,0,0,32'h00, 0,0,12'h100,1,0,0));
        vecs.push_back(mk(1,0,0,32'h00, 0,0,12'h100,1,0,0));
        vecs.push_back(mk(1,0,0,32'h00, 0,0,12'h100,1,0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h100,0,0,0));
        vecs.push_back(mk(1,1,1,32'hB0, 1,1,12'h100,0,0,0));
        vecs.push_back(mk(1,1,0,32'hB1, 1,0,12'h101,0,0,0));
        vecs.push_back(mk(1,1,0,32'hB2, 1,0,12'h101,0,0,0));
        vecs.push_back(mk(1,1,1,32'hB3, 1,1,12'h101,0,0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h102,0,1,0));
        vecs.push_back(mk(0,1,0,32'h00, 0,0,12'h102,0,0,1));
        vecs.push_back(mk(0,1,0,32'h00, 0,0,12'h102,0,0,0));
        runTable("stall");
`ifdef OUT_WRMEM_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL stall_cnt: got %0d expected 2", stall_cnt);
        end
`endif

        // Address wrap with burst_len 0 acting as 1.
        base_addr = 12'hFFE; size = 16'd3; burst_len = 16'd0;
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h102,0,0,0));
        vecs.push_back(mk(1,1,1,32'hC0, 0,0,12'hFFE,0,0,0));
        vecs.push_back(mk(1,1,1,32'hC0, 1,1,12'hFFE,0,0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'hFFF,0,1,0));
        vecs.push_back(mk(1,1,1,32'hC1, 0,0,12'hFFF,0,0,0));
        vecs.push_back(mk(1,1,1,32'hC1, 1,1,12'hFFF,0,0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h000,0,1,0));
        vecs.push_back(mk(1,1,1,32'hC2, 0,0,12'h000,0,0,0));
        vecs.push_back(mk(1,1,1,32'hC2, 1,1,12'h000,0,0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h001,0,1,0));
        vecs.push_back(mk(0,1,0,32'h00, 0,0,12'h001,0,0,1));
        vecs.push_back(mk(0,1,0,32'h00, 0,0,12'h001,0,0,0));
        runTable("wrap");

        // size 0: straight to DONE, held start does not retrigger.
        base_addr = 12'h020; size = 16'd0; burst_len = 16'd4;
        vecs.push_back(mk(1,1,1,32'hD0, 0,0,12'h001,0,0,0));
        vecs.push_back(mk(1,1,1,32'hD0, 0,0,12'h020,0,0,0));
        vecs.push_back(mk(1,1,1,32'hD0, 0,0,12'h020,0,0,1));
        vecs.push_back(mk(1,1,1,32'hD0, 0,0,12'h020,0,0,1));
        vecs.push_back(mk(0,1,1,32'hD0, 0,0,12'h020,0,0,1));
        vecs.push_back(mk(0,1,1,32'hD0, 0,0,12'h020,0,0,0));
        vecs.push_back(mk(0,1,1,32'hD0, 0,0,12'h020,0,0,0));
        runTable("size0");

        // Reset in the middle of a burst after one write.
        base_addr = 12'h040; size = 16'd4; burst_len = 16'd4;
        vecs.push_back(mk(1,1,1,32'hE0, 0,0,12'h020,0,0,0));
        vecs.push_back(mk(1,1,1,32'hE0, 0,0,12'h040,0,0,0));
        vecs.push_back(mk(1,1,1,32'hE0, 1,1,12'h040,0,0,0));
        runTable("prereset");
        @(negedge clk);
        bus_if.OUT_data = 32'hE1;
        start = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("reset_async", 0, mk(0,1,1,32'hE1, 0,0,12'h000,0,0,0));
        @(negedge clk);
        #1;
        checkOutput("reset_hold", 0, mk(0,1,1,32'hE1, 0,0,12'h000,0,0,0));
        rst = 1'b0;

        base_addr = 12'h080; size = 16'd2; burst_len = 16'd2;
        vecs.push_back(mk(0,1,0,32'h00, 0,0,12'h000,0,0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h000,0,0,0));
        vecs.push_back(mk(1,1,1,32'hF0, 0,0,12'h080,0,0,0));
        vecs.push_back(mk(1,1,1,32'hF0, 1,1,12'h080,0,0,0));
        vecs.push_back(mk(1,1,1,32'hF1, 1,1,12'h081,0,0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0,12'h082,0,1,0));
        vecs.push_back(mk(0,1,0,32'h00, 0,0,12'h082,0,0,1));
        vecs.push_back(mk(0,1,0,32'h00, 0,0,12'h082,0,0,0));
        runTable("postreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
